// File: rtl/fir_coef_ctrl.sv
// Coefficient loader for the transposed FIR: fills a shadow bank over a
// valid/ready stream and swaps it onto C atomically, then masks y_valid.
module fir_coef_ctrl #(
    parameter int              BW     = 12,
    parameter int              N      = 5,
    parameter logic [N*BW-1:0] C_INIT = '0
) (
    input  logic          CK,
    input  logic          RB,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [BW-1:0] cfg_data,
    input  logic          cfg_last,
    input  logic          cfg_abort,
    input  logic          swap_en,
    output logic [N*BW-1:0] C,
    output logic          coef_upd,
    output logic          y_valid,
    output logic          cfg_err,
    output logic [7:0]    err_cnt,
    output logic [1:0]    state
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        PEND   = 2'd2,
        SETTLE = 2'd3
    } st_t;

    st_t             st;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   scnt;
    logic [BW-1:0]   shadow [N];
    logic [N*BW-1:0] c_r;

    logic xfer;
    logic last_word;
    logic frame_err;
    logic abort_err;
    logic err_ev;

    assign cfg_ready = ((st == IDLE) || (st == LOAD)) && !cfg_abort;
    assign xfer      = cfg_valid && cfg_ready;
    assign last_word = (cnt == CW'(N - 1));

    // A load must end with cfg_last on exactly the N-th word.
    assign frame_err = xfer && (((st == IDLE) && cfg_last) ||
                                ((st == LOAD) && (last_word != cfg_last)));
    assign abort_err = cfg_abort && ((st == LOAD) || (st == PEND));
    assign err_ev    = frame_err || abort_err;

    assign C     = c_r;
    assign state = st;

    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            st       <= IDLE;
            c_r      <= C_INIT;
            cnt      <= '0;
            scnt     <= '0;
            coef_upd <= 1'b0;
            y_valid  <= 1'b0;
            cfg_err  <= 1'b0;
            err_cnt  <= '0;
            for (int k = 0; k < N; k++) shadow[k] <= '0;
        end else begin
            coef_upd <= 1'b0;
            cfg_err  <= err_ev;
            if (err_ev && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;

            case (st)
                IDLE: begin
                    if (xfer) begin
                        shadow[0] <= cfg_data;
                        if (cfg_last) begin
                            cnt <= '0;
                        end else begin
                            cnt <= CW'(1);
                            st  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (cfg_abort) begin
                        st  <= IDLE;
                        cnt <= '0;
                        for (int k = 0; k < N; k++) shadow[k] <= '0;
                    end else if (xfer) begin
                        shadow[cnt] <= cfg_data;
                        if (last_word && cfg_last) begin
                            st  <= PEND;
                            cnt <= '0;
                        end else if (!last_word && !cfg_last) begin
                            cnt <= cnt + CW'(1);
                        end else begin
                            st  <= IDLE;
                            cnt <= '0;
                        end
                    end
                end
                PEND: begin
                    if (cfg_abort) begin
                        st <= IDLE;
                        for (int k = 0; k < N; k++) shadow[k] <= '0;
                    end else if (swap_en) begin
                        for (int k = 0; k < N; k++)
                            c_r[k*BW +: BW] <= shadow[k];
                        coef_upd <= 1'b1;
                        y_valid  <= 1'b0;
                        scnt     <= CW'(N - 1);
                        st       <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Hold y_valid low for N-1 cycles while the taps refill.
                    if (scnt == CW'(1)) begin
                        scnt    <= '0;
                        y_valid <= 1'b1;
                        st      <= IDLE;
                    end else begin
                        scnt <= scnt - CW'(1);
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
